local_inject_arbiter: RTL and testbench
=======================================

# local_inject_arbiter

Round-robin scheduler that shares one router Local input port between NUM_REQ packet injectors (PE traffic sources) in the mesh NoC simulator. It accepts the injectors' request/grant handshake (Req held until a one-cycle Gnt) and selects one requester at a time. It latches the selected packet and forwards it to the router using the same Req/Gnt/Full handshake. It also counts the packets it has forwarded.

## Interface
- NUM_REQ, 4, number of injectors sharing the port (2..8)
- PTR_W, 2, pointer/owner width, equal to ceil(log2(NUM_REQ))
- dataWidth, 32, packet width in bits
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low
- ReqIn  in  NUM_REQ  per-injector request; bit i belongs to injector i
- PacketIn  in  NUM_REQ*dataWidth  injector i's packet is at bits [i*dataWidth +: dataWidth]; stable while ReqIn[i]=1
- GntOut  out  NUM_REQ  per-injector grant; one-cycle pulse, registered
- FullOut  out  NUM_REQ  per-injector full indication; every bit equals RtrFull (combinational)
- ReqRtr  out  1  request to the router Local port, registered
- GntRtr  in  1  grant from the router
- RtrFull  in  1  router Local FIFO full
- PacketRtr  out  dataWidth  latched packet presented to the router, registered
- Owner  out  PTR_W  index of the injector currently being served
- ServedCount  out  16  total packets forwarded; wraps modulo 2^16

## Operation
- Reset (reset=0) clears all registers immediately: STATE=IDLE, ReqRtr=0, GntOut=0, PacketRtr=0, Owner=0, Ptr=0, ServedCount=0. This applies mid-operation too; any in-flight packet is dropped.
- Ptr is the internal round-robin priority pointer. Search order is Ptr, Ptr+1, …, wrapping modulo NUM_REQ.
- IDLE (2'b00): the block waits until some ReqIn bit is 1 and RtrFull=0. Then it:
  - selects winner w, the first set ReqIn bit in search order;
  - sets PacketRtr <= PacketIn[w], Owner <= w, ReqRtr <= 1;
  - moves to WAIT_GNT.
- IDLE with RtrFull=1: the block stays in IDLE and grants nothing. Pending requests remain pending.
- WAIT_GNT (2'b10): ReqRtr and PacketRtr are held. When GntRtr=1 the block:
  - sets ReqRtr <= 0 and GntOut[Owner] <= 1;
  - sets Ptr <= (Owner+1) mod NUM_REQ, computed without a power-of-two assumption;
  - increments ServedCount;
  - moves to RELEASE.
- RTR full during WAIT_GNT: the request stays held until the router grants. Full is checked only in IDLE.
- RELEASE (2'b11): GntOut <= 0 and the block returns to IDLE. This state lets the served injector drop ReqIn before the next arbitration, so the same request is never granted twice.
- ReqIn[Owner] dropping during WAIT_GNT (protocol violation): the latched packet is still forwarded, and GntOut is still pulsed.
- ReqIn bits of non-owners are ignored outside IDLE. They are not queued; they are re-evaluated in IDLE.
- At most one GntOut bit is ever 1. GntOut and ReqRtr are never both 1.
- ServedCount wraps from 16'hFFFF to 0.
- State 2'b01 is unused; if it is entered, the next state is IDLE and all outputs are as in reset.

## Timing
- Arbitration to router request: ReqIn sampled at IDLE edge k gives ReqRtr=1 and a valid PacketRtr after edge k.
- Router grant to injector grant: GntRtr=1 sampled at edge m gives GntOut[Owner]=1 after edge m, for exactly one cycle, cleared after edge m+1.
- Minimum service time is 3 cycles per packet, so peak throughput is 1 packet per 3 cycles. This applies when GntRtr arrives in the first WAIT_GNT cycle.
- FullOut has zero latency from RtrFull.
- Owner is stable from the IDLE->WAIT_GNT edge until the next arbitration.

## Test plan
- Reset mid-WAIT_GNT: with ReqRtr=1, pull reset low -> ReqRtr, GntOut, PacketRtr, Owner, ServedCount are all 0 immediately, and STATE=IDLE after reset releases.
- Single requester: ReqIn=4'b0100, PacketIn[2]=32'hA5A5_0003, GntRtr returned 1 cycle after ReqRtr -> PacketRtr=32'hA5A5_0003, Owner=2, GntOut=4'b0100 for one cycle, ServedCount=1, Ptr=3.
- Round robin: from reset, hold ReqIn=4'b1111 with instant GntRtr, and each injector drops Req after its grant, then re-requests -> grant order 0,1,2,3,0; ServedCount=5 after 15 cycles.
- Full blocking: RtrFull=1 with ReqIn=4'b0011 for 10 cycles -> ReqRtr stays 0 and FullOut=4'b1111. Release RtrFull -> injector 0 is served first.
- Delayed grant: GntRtr held 0 for 7 cycles while RtrFull toggles -> ReqRtr stays 1 and PacketRtr is unchanged; GntOut pulses once after GntRtr=1.
- Counter wrap: preload 65535 grants (or force ServedCount=16'hFFFF) and serve one packet -> ServedCount=0.

Source files
------------

// File: rtl/local_inject_arbiter.sv
// rtl/local_inject_arbiter.sv - round-robin sharing of one router Local port among NUM_REQ injectors
module local_inject_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PTR_W     = 2,
  parameter int dataWidth = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             ReqIn,
  input  logic [NUM_REQ*dataWidth-1:0]   PacketIn,
  output logic [NUM_REQ-1:0]             GntOut,
  output logic [NUM_REQ-1:0]             FullOut,
  output logic                           ReqRtr,
  input  logic                           GntRtr,
  input  logic                           RtrFull,
  output logic [dataWidth-1:0]           PacketRtr,
  output logic [PTR_W-1:0]               Owner,
  output logic [15:0]                    ServedCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    UNUSED   = 2'b01,
    WAIT_GNT = 2'b10,
    RELEASE  = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [dataWidth-1:0]   pkt_q, pkt_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W:0]         cand;
  logic [PTR_W-1:0]       owner_inc;

  // Walk Ptr, Ptr+1, ... with an explicit wrap so NUM_REQ need not be a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!win_found && ReqIn[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign owner_inc = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gnt_d   = '0;
    pkt_d   = pkt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found && !RtrFull) begin
          pkt_d   = PacketIn[win_idx*dataWidth +: dataWidth];
          owner_d = win_idx;
          req_d   = 1'b1;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (GntRtr) begin
          req_d          = 1'b0;
          gnt_d[owner_q] = 1'b1;
          ptr_d          = owner_inc;
          cnt_d          = cnt_q + 16'd1;
          state_d        = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        pkt_d   = '0;
        owner_d = '0;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      gnt_q   <= '0;
      pkt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      pkt_q   <= pkt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GntOut      = gnt_q;
  assign FullOut     = {NUM_REQ{RtrFull}};
  assign ReqRtr      = req_q;
  assign PacketRtr   = pkt_q;
  assign Owner       = owner_q;
  assign ServedCount = cnt_q;

endmodule

// File: tb/tb_local_inject_arbiter.sv
// tb/tb_local_inject_arbiter.sv - directed self-checking bench for local_inject_arbiter
module tb_local_inject_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   ReqIn = '0;
  logic [127:0] PacketIn = '0;
  logic [3:0]   GntOut;
  logic [3:0]   FullOut;
  logic         ReqRtr;
  logic         GntRtr = 1'b0;
  logic         RtrFull = 1'b0;
  logic [31:0]  PacketRtr;
  logic [1:0]   Owner;
  logic [15:0]  ServedCount;

  int tests_run = 0;
  int tests_failed = 0;

  local_inject_arbiter #(.NUM_REQ(4), .PTR_W(2), .dataWidth(32)) dut (
    .clk(clk), .reset(reset), .ReqIn(ReqIn), .PacketIn(PacketIn),
    .GntOut(GntOut), .FullOut(FullOut), .ReqRtr(ReqRtr), .GntRtr(GntRtr),
    .RtrFull(RtrFull), .PacketRtr(PacketRtr), .Owner(Owner), .ServedCount(ServedCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ReqIn = '0; GntRtr = 1'b0; RtrFull = 1'b0;
    reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  int          order[$];
  logic [31:0] pkt_hold;
  int          pulses;

  initial begin
    do_reset();
    check("rst_req", ReqRtr, 0);
    check("rst_gnt", GntOut, 0);
    check("rst_pkt", PacketRtr, 0);
    check("rst_owner", Owner, 0);
    check("rst_cnt", ServedCount, 0);

    // Single requester on injector 2
    PacketIn[2*32 +: 32] = 32'hA5A5_0003;
    ReqIn = 4'b0100;
    tick();
    check("single_req", ReqRtr, 1);
    check("single_pkt", PacketRtr, 32'hA5A5_0003);
    check("single_owner", Owner, 2);
    GntRtr = 1'b1;
    tick();
    check("single_gnt", GntOut, 4'b0100);
    check("single_req_off", ReqRtr, 0);
    check("single_cnt", ServedCount, 1);
    check("single_ptr", dut.ptr_q, 3);
    GntRtr = 1'b0; ReqIn = '0;
    tick();
    check("single_gnt_clr", GntOut, 0);
    check("single_idle", dut.state_q, 2'b00);

    // Reset asserted asynchronously while waiting for the router
    ReqIn = 4'b0100;
    tick();
    check("mid_req_set", ReqRtr, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req", ReqRtr, 0);
    check("mid_rst_gnt", GntOut, 0);
    check("mid_rst_pkt", PacketRtr, 0);
    check("mid_rst_owner", Owner, 0);
    check("mid_rst_cnt", ServedCount, 0);
    ReqIn = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("mid_rst_state", dut.state_q, 2'b00);

    // Round robin with all four requesting and instant router grant
    do_reset();
    ReqIn = 4'b1111; GntRtr = 1'b1;
    order.delete();
    for (int c = 0; c < 15; c++) begin
      tick();
      check("rr_excl", {31'd0, ($onehot0(GntOut) && !((|GntOut) && ReqRtr))}, 1);
      for (int i = 0; i < 4; i++) if (GntOut[i]) order.push_back(i);
      ReqIn = 4'b1111 & ~GntOut;
    end
    check("rr_cnt", ServedCount, 5);
    check("rr_ngrants", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("rr_order%0d", i), order[i], i % 4);
    GntRtr = 1'b0; ReqIn = '0;

    // Router full blocks arbitration
    do_reset();
    RtrFull = 1'b1; ReqIn = 4'b0011;
    #1;
    check("full_out", FullOut, 4'b1111);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("full_noreq", ReqRtr, 0);
    end
    check("full_out_hold", FullOut, 4'b1111);
    RtrFull = 1'b0;
    #1;
    check("full_out_clr", FullOut, 4'b0000);
    tick();
    check("full_rel_req", ReqRtr, 1);
    check("full_rel_owner", Owner, 0);

    // Delayed router grant with RtrFull toggling
    do_reset();
    PacketIn[0 +: 32] = 32'h1234_5678;
    ReqIn = 4'b0001;
    tick();
    pkt_hold = 32'h1234_5678;
    check("dly_pkt0", PacketRtr, pkt_hold);
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      RtrFull = ~RtrFull;
      tick();
      check("dly_req", ReqRtr, 1);
      check("dly_pkt", PacketRtr, pkt_hold);
      if (GntOut != 0) pulses++;
    end
    RtrFull = 1'b0; GntRtr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      GntRtr = 1'b0;
      if (GntOut != 0) begin
        pulses++;
        check("dly_gnt", GntOut, 4'b0001);
        ReqIn = '0;
      end
    end
    check("dly_pulses", pulses, 1);

    // Counter wrap from 16'hFFFF
    do_reset();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("wrap_pre", ServedCount, 16'hFFFF);
    ReqIn = 4'b0010; GntRtr = 1'b1;
    tick();
    tick();
    check("wrap_gnt", GntOut, 4'b0010);
    check("wrap_cnt", ServedCount, 0);
    ReqIn = '0; GntRtr = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
